i2s_tx_sched: RTL and testbench
===============================

I2S_TX_SCHED -- requirements
Module: i2s_tx_sched

Interface
REQ-001 Parameter AUDIO_DW, default 16, sample width and prescaler width.
REQ-002 Parameter N_SRC, default 4, number of stereo sample sources (2..8).
REQ-003 The block SHALL use one clock and a synchronous, active-low reset: i_tx_sclk in 1, rising-edge clock; i_tx_rst_n in 1, synchronous active-low reset.
REQ-004 i_enable  in  1  run request.
REQ-005 i_prescaler  in  AUDIO_DW  slot length in sclk cycles, as used by the TX serializer.
REQ-006 i_src_mask  in  N_SRC  per-source arbitration enable.
REQ-007 i_src_valid  in  N_SRC  per-source sample available.
REQ-008 i_src_left, i_src_right  in  N_SRC*AUDIO_DW each  packed samples; source k at bits [k*AUDIO_DW +: AUDIO_DW].
REQ-009 i_mute_on_underrun  in  1  1 = send zeros on underrun, 0 = repeat last sample.
REQ-010 i_clr_underrun  in  1  clear underrun counter.
REQ-011 o_src_ready  out  N_SRC  one-hot accept pulse.
REQ-012 o_tx_left, o_tx_right  out  AUDIO_DW each  sample to the TX serializer.
REQ-013 o_tx_prescaler  out  AUDIO_DW  sanitized prescaler to the TX serializer.
REQ-014 o_tx_rst_n  out  1  active-low reset to the TX serializer.
REQ-015 o_frame_strobe  out  1  one-cycle pulse at each frame start.
REQ-016 o_grant_id  out  clog2(N_SRC)  index of the last granted source.
REQ-017 o_underrun_cnt  out  16  saturating underrun count.

Function
REQ-018 States SHALL be IDLE, START and RUN: IDLE->START when i_enable=1; START->RUN after exactly one cycle; RUN->IDLE at the last cycle of the current frame once i_enable=0.
REQ-019 The block SHALL drive o_tx_rst_n=0 in IDLE and START, and 1 in RUN.
REQ-020 In START, the block SHALL latch P = sanitized i_prescaler: 0 or values >AUDIO_DW map to AUDIO_DW, otherwise unchanged; o_tx_prescaler=P; i_prescaler changes outside START SHALL be ignored.
REQ-021 In RUN, frame counter f SHALL count 0..2P-1 and wrap; f SHALL be 0 on the first RUN cycle.
REQ-022 o_frame_strobe SHALL be high when f==0 in RUN.
REQ-023 The fetch point SHALL be f==P (start of the right slot); at all other cycles o_tx_left/o_tx_right SHALL hold their values.
REQ-024 Round-robin arbitration at the fetch point: search eligible sources (mask&valid) starting at pointer ptr, ascending with wrap; grant the first one found.
REQ-025 On grant k: o_src_ready[k]=1 for that single cycle; o_tx_left/o_tx_right load source k's samples next cycle; o_grant_id=k; ptr=(k+1) mod N_SRC.
REQ-026 A source SHALL hold valid and data until it receives ready; transfer is valid&ready in the same cycle.
REQ-027 Underrun (no eligible source at fetch): no ready; ptr unchanged; outputs zero if i_mute_on_underrun=1, else hold; o_underrun_cnt increments, saturating at 0xFFFF.
REQ-028 i_clr_underrun SHALL zero the counter; if an underrun occurs in the same cycle, the count SHALL become 1.
REQ-029 Mask or valid changes between fetch points SHALL have no effect; only values at f==P count.
REQ-030 i_enable deassert then reassert within the same frame SHALL keep RUN uninterrupted.

Reset
REQ-031 On i_tx_rst_n=0 at a clock edge: state IDLE, f=0, ptr=0, P=AUDIO_DW, o_tx_prescaler=AUDIO_DW, o_tx_rst_n=0, o_tx_left=o_tx_right=0, o_src_ready=0, o_frame_strobe=0, o_grant_id=0, o_underrun_cnt=0.
REQ-032 Reset asserted mid-frame SHALL take effect at the next edge with no frame completion and no ready pulse.

Structure
REQ-033 Shared package i2s_pkg SHALL hold the AUDIO_DW default, the state enumeration, and the underrun counter width/saturation constant.
REQ-034 Round-robin search SHALL be a sub-module i2s_rr_arb (inputs: request vector, pointer; outputs: grant one-hot, index, any).

Verification
REQ-035 P=4, all sources valid and masked, 3 frames -> ready pulses at f==4 to sources 0,1,2 in order; o_frame_strobe every 8 cycles.
REQ-036 Only source 2 valid, ptr=3 -> grant 2 via wrap; o_grant_id=2; next ptr=3.
REQ-037 No source valid, mute=1, 2 frames -> outputs 0, o_underrun_cnt=2; mute=0 -> previous sample held.
REQ-038 i_prescaler=0 then 40 (AUDIO_DW=16) -> o_tx_prescaler=16 in both cases; P=16 frame length 32 cycles.
REQ-039 i_enable dropped at f=3 with P=4 -> RUN until f=7, then IDLE with o_tx_rst_n=0; underrun at counter 0xFFFF stays 0xFFFF; clear plus simultaneous underrun -> count 1.
REQ-040 Reset asserted at f=4 -> no ready pulse that cycle; all outputs at reset values the next cycle.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmit scheduler.
package i2s_pkg;

    // Default sample width, also used as the default prescaler
    localparam int unsigned AUDIO_DW_DEF = 16;

    // Underrun counter width and its saturation value
    localparam int unsigned UNDERRUN_W = 16;
    localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = 16'hFFFF;

    // Scheduler states
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StRun
    } tx_state_e;

endpackage

// File: rtl/i2s_rr_arb.sv
// Round-robin search: first requester at or after ptr, ascending with wrap.
module i2s_rr_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // (ptr + off) mod N; off < N and ptr < N, so one subtraction suffices
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int unsigned off);
        int unsigned s;
        s = 32'(p) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Scan from the pointer and keep only the first hit
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && req[wrap_idx(ptr, i)]) begin
                gnt[wrap_idx(ptr, i)] = 1'b1;
                idx                   = wrap_idx(ptr, i);
                any                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_tx_sched.sv
// I2S transmit scheduler: frames the serializer and feeds it one stereo
// sample per frame, chosen round-robin from N_SRC sources.
module i2s_tx_sched
    import i2s_pkg::*;
#(
    parameter int unsigned AUDIO_DW = AUDIO_DW_DEF,
    parameter int unsigned N_SRC    = 4
) (
    input  logic                      i_tx_sclk,
    input  logic                      i_tx_rst_n,
    input  logic                      i_enable,
    input  logic [AUDIO_DW-1:0]       i_prescaler,
    input  logic [N_SRC-1:0]          i_src_mask,
    input  logic [N_SRC-1:0]          i_src_valid,
    input  logic [N_SRC*AUDIO_DW-1:0] i_src_left,
    input  logic [N_SRC*AUDIO_DW-1:0] i_src_right,
    input  logic                      i_mute_on_underrun,
    input  logic                      i_clr_underrun,
    output logic [N_SRC-1:0]          o_src_ready,
    output logic [AUDIO_DW-1:0]       o_tx_left,
    output logic [AUDIO_DW-1:0]       o_tx_right,
    output logic [AUDIO_DW-1:0]       o_tx_prescaler,
    output logic                      o_tx_rst_n,
    output logic                      o_frame_strobe,
    output logic [$clog2(N_SRC)-1:0]  o_grant_id,
    output logic [UNDERRUN_W-1:0]     o_underrun_cnt
);

    localparam int unsigned GIW = $clog2(N_SRC);
    // Frame counter must reach 2*AUDIO_DW-1
    localparam int unsigned FW  = AUDIO_DW + 1;

    tx_state_e             state_q, state_d;
    logic [FW-1:0]         f_q, f_d;
    logic [AUDIO_DW-1:0]   p_q, p_d;
    logic [GIW-1:0]        ptr_q, ptr_d;
    logic [GIW-1:0]        gid_q, gid_d;
    logic [AUDIO_DW-1:0]   left_q, left_d;
    logic [AUDIO_DW-1:0]   right_q, right_d;
    logic [UNDERRUN_W-1:0] cnt_q, cnt_d;

    logic [AUDIO_DW-1:0]   p_san;
    logic [FW-1:0]         p_ext;
    logic                  frame_last;
    logic                  fetch;
    logic [N_SRC-1:0]      arb_gnt;
    logic [GIW-1:0]        arb_idx;
    logic                  arb_any;
    logic                  underrun;

    // Zero or oversize prescalers fall back to one slot per sample bit
    assign p_san = (i_prescaler == '0 || i_prescaler > AUDIO_DW[AUDIO_DW-1:0])
                   ? AUDIO_DW[AUDIO_DW-1:0] : i_prescaler;

    assign p_ext      = FW'(p_q);
    assign frame_last = (f_q == (p_ext << 1) - FW'(1));
    // Fetch at the start of the right slot
    assign fetch      = (state_q == StRun) && (f_q == p_ext);
    assign underrun   = fetch && !arb_any;

    i2s_rr_arb #(
        .N  (N_SRC),
        .IW (GIW)
    ) u_arb (
        .req (i_src_mask & i_src_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Ready is gated by reset so a reset cycle never completes a transfer
    assign o_src_ready    = (fetch && i_tx_rst_n) ? arb_gnt : '0;
    assign o_frame_strobe = (state_q == StRun) && (f_q == '0);
    assign o_tx_rst_n     = (state_q == StRun);
    assign o_tx_prescaler = p_q;
    assign o_tx_left      = left_q;
    assign o_tx_right     = right_q;
    assign o_grant_id     = gid_q;
    assign o_underrun_cnt = cnt_q;

    // State sequencing and frame counter
    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        p_d     = p_q;
        unique case (state_q)
            StIdle: begin
                f_d = '0;
                if (i_enable) state_d = StStart;
            end
            StStart: begin
                p_d     = p_san;
                f_d     = '0;
                state_d = StRun;
            end
            StRun: begin
                // Enable is only looked at on the last cycle of a frame
                if (frame_last) begin
                    f_d = '0;
                    if (!i_enable) state_d = StIdle;
                end else begin
                    f_d = f_q + FW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sample capture, pointer advance and underrun accounting
    always_comb begin
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        left_d  = left_q;
        right_d = right_q;
        cnt_d   = cnt_q;
        if (fetch && arb_any) begin
            left_d  = i_src_left[arb_idx*AUDIO_DW +: AUDIO_DW];
            right_d = i_src_right[arb_idx*AUDIO_DW +: AUDIO_DW];
            gid_d   = arb_idx;
            ptr_d   = (arb_idx == GIW'(N_SRC - 1)) ? '0 : arb_idx + 1'b1;
        end
        if (underrun) begin
            if (i_mute_on_underrun) begin
                left_d  = '0;
                right_d = '0;
            end
            if (cnt_q != UNDERRUN_MAX) cnt_d = cnt_q + 1'b1;
        end
        if (i_clr_underrun) cnt_d = underrun ? UNDERRUN_W'(1) : '0;
    end

    // State registers with synchronous reset
    always_ff @(posedge i_tx_sclk) begin
        if (!i_tx_rst_n) begin
            state_q <= StIdle;
            f_q     <= '0;
            p_q     <= AUDIO_DW[AUDIO_DW-1:0];
            ptr_q   <= '0;
            gid_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            p_q     <= p_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            left_q  <= left_d;
            right_q <= right_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Self-checking bench for i2s_tx_sched with a frame-level reference model.
module tb_i2s_tx_sched;

    localparam int DW = 16;
    localparam int NS = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic [DW-1:0]  prescaler;
    logic [NS-1:0]  mask;
    logic [NS-1:0]  valid;
    logic [NS*DW-1:0] src_l;
    logic [NS*DW-1:0] src_r;
    logic           mute;
    logic           clr;
    logic [NS-1:0]  rdy;
    logic [DW-1:0]  tx_l;
    logic [DW-1:0]  tx_r;
    logic [DW-1:0]  tx_p;
    logic           tx_rst_n;
    logic           strobe;
    logic [1:0]     gid;
    logic [15:0]    ucnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    i2s_tx_sched #(
        .AUDIO_DW (DW),
        .N_SRC    (NS)
    ) dut (
        .i_tx_sclk          (clk),
        .i_tx_rst_n         (rst_n),
        .i_enable           (enable),
        .i_prescaler        (prescaler),
        .i_src_mask         (mask),
        .i_src_valid        (valid),
        .i_src_left         (src_l),
        .i_src_right        (src_r),
        .i_mute_on_underrun (mute),
        .i_clr_underrun     (clr),
        .o_src_ready        (rdy),
        .o_tx_left          (tx_l),
        .o_tx_right         (tx_r),
        .o_tx_prescaler     (tx_p),
        .o_tx_rst_n         (tx_rst_n),
        .o_frame_strobe     (strobe),
        .o_grant_id         (gid),
        .o_underrun_cnt     (ucnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle, 1=start, 2=run; f is position within frame
    int          m_mode = 0;
    int          m_f    = 0;
    int          m_p    = 16;
    int          m_ptr  = 0;
    int          m_gid  = 0;
    int          m_cnt  = 0;
    logic [15:0] m_l    = '0;
    logic [15:0] m_r    = '0;

    function automatic int pick(input logic [NS-1:0] req, input int ptr);
        for (int i = 0; i < NS; i++)
            if (req[(ptr + i) % NS]) return (ptr + i) % NS;
        return -1;
    endfunction

    // Compare every output against the model, then advance the model one cycle
    always @(negedge clk) begin
        if (chk_en) begin
            bit fetch;
            int w;
            logic [NS-1:0] exp_rdy;
            fetch   = (m_mode == 2) && (m_f == m_p);
            w       = fetch ? pick(mask & valid, m_ptr) : -1;
            exp_rdy = (w >= 0 && rst_n) ? NS'(1 << w) : '0;
            chk("ready", 32'(rdy), 32'(exp_rdy));
            chk("strobe", 32'(strobe), 32'((m_mode == 2) && (m_f == 0)));
            chk("tx_rst_n", 32'(tx_rst_n), 32'(m_mode == 2));
            chk("prescaler", 32'(tx_p), m_p);
            chk("left", 32'(tx_l), 32'(m_l));
            chk("right", 32'(tx_r), 32'(m_r));
            chk("grant_id", 32'(gid), m_gid);
            chk("underrun_cnt", 32'(ucnt), m_cnt);
            if (!rst_n) begin
                m_mode = 0; m_f = 0; m_p = 16; m_ptr = 0; m_gid = 0; m_cnt = 0;
                m_l = '0; m_r = '0;
            end else begin
                bit ur;
                ur = fetch && (w < 0);
                if (w >= 0) begin
                    m_l   = src_l[w*DW +: DW];
                    m_r   = src_r[w*DW +: DW];
                    m_gid = w;
                    m_ptr = (w + 1) % NS;
                end
                if (ur && mute) begin
                    m_l = '0;
                    m_r = '0;
                end
                if (clr) m_cnt = ur ? 1 : 0;
                else if (ur && m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
                case (m_mode)
                    0: if (enable) m_mode = 1;
                    1: begin
                        m_p    = (prescaler == 0 || prescaler > DW) ? DW : int'(prescaler);
                        m_f    = 0;
                        m_mode = 2;
                    end
                    default: begin
                        if (m_f == 2 * m_p - 1) begin
                            m_f = 0;
                            if (!enable) m_mode = 0;
                        end else begin
                            m_f = m_f + 1;
                        end
                    end
                endcase
            end
        end
    end

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the negedge of the f==0 cycle
    task automatic wait_strobe(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (strobe) return;
        end
        total++;
        bad++;
        $display("FAIL %s: no frame strobe within 100 cycles", name);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!tx_rst_n) return;
        end
        total++;
        bad++;
        $display("FAIL %s: still running after 100 cycles", name);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        enable    = 1'b0;
        prescaler = 16'd4;
        mask      = 4'hF;
        valid     = 4'hF;
        src_l     = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        src_r     = {16'h2003, 16'h2002, 16'h2001, 16'h2000};
        mute      = 1'b0;
        clr       = 1'b0;
        drive();
        chk_en = 1'b1;
        drive();
        @(negedge clk);
        chk("rst prescaler", 32'(tx_p), 32'd16);
        chk("rst tx_rst_n", 32'(tx_rst_n), 32'd0);
        chk("rst left", 32'(tx_l), 32'd0);
        rst_n = 1'b1;

        // P=4, everyone eligible: grants 0,1,2 at f==4, strobe every 8
        drive();
        enable = 1'b1;
        wait_strobe("first frame");
        repeat (4) @(negedge clk);
        chk("rr ready0", 32'(rdy), 32'h1);
        repeat (4) @(negedge clk);
        chk("strobe period", 32'(strobe), 32'd1);
        repeat (4) @(negedge clk);
        chk("rr ready1", 32'(rdy), 32'h2);
        repeat (8) @(negedge clk);
        chk("rr ready2", 32'(rdy), 32'h4);

        // Two muted underrun frames
        wait_strobe("mute setup");
        drive();
        clr   = 1'b1;
        valid = 4'h0;
        mute  = 1'b1;
        drive();
        clr = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("mute cnt", 32'(ucnt), 32'd2);
        chk("mute left", 32'(tx_l), 32'd0);
        chk("mute right", 32'(tx_r), 32'd0);

        // Load source 3 (pointer is 3), then hold it across an unmuted underrun
        drive();
        valid = 4'hF;
        mute  = 1'b0;
        wait_strobe("load");
        repeat (5) @(negedge clk);
        chk("load left", 32'(tx_l), 32'h1003);
        chk("load right", 32'(tx_r), 32'h2003);
        chk("load gid", 32'(gid), 32'd3);
        drive();
        valid = 4'h0;
        wait_strobe("hold");
        repeat (5) @(negedge clk);
        chk("hold left", 32'(tx_l), 32'h1003);
        chk("hold cnt", 32'(ucnt), 32'd3);

        // Only source 2: first grant moves ptr to 3, second wraps back to 2
        drive();
        valid = 4'b0100;
        wait_strobe("src2 a");
        repeat (4) @(negedge clk);
        chk("src2 ready a", 32'(rdy), 32'h4);
        wait_strobe("src2 b");
        repeat (4) @(negedge clk);
        chk("src2 ready wrap", 32'(rdy), 32'h4);
        @(negedge clk);
        chk("src2 gid", 32'(gid), 32'd2);
        chk("src2 left", 32'(tx_l), 32'h1002);

        // Clear coinciding with an underrun leaves a count of one
        drive();
        valid = 4'h0;
        wait_strobe("clr");
        repeat (3) @(negedge clk);
        drive();
        clr = 1'b1;
        drive();
        clr = 1'b0;
        @(negedge clk);
        chk("clr+underrun", 32'(ucnt), 32'd1);

        // Enable dropped at f=3: run to f=7, then idle
        wait_strobe("stop");
        repeat (2) @(negedge clk);
        drive();
        enable = 1'b0;
        repeat (5) @(negedge clk);
        chk("stop f7 running", 32'(tx_rst_n), 32'd1);
        @(negedge clk);
        chk("stop idle", 32'(tx_rst_n), 32'd0);

        // Prescaler sanitising: 0 and 40 both give 16, frame of 32
        drive();
        prescaler = 16'd0;
        enable    = 1'b1;
        wait_strobe("p0");
        chk("p0 prescaler", 32'(tx_p), 32'd16);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (strobe) break;
        end
        chk("p16 frame length", 32'(n), 32'd32);
        drive();
        enable    = 1'b0;
        prescaler = 16'd40;
        wait_idle("p40 idle");
        drive();
        enable = 1'b1;
        wait_strobe("p40");
        chk("p40 prescaler", 32'(tx_p), 32'd16);

        // Reset at the fetch point of a P=4 frame
        drive();
        enable = 1'b0;
        wait_idle("rst idle");
        drive();
        prescaler = 16'd4;
        valid     = 4'hF;
        enable    = 1'b1;
        wait_strobe("rst frame");
        repeat (3) @(negedge clk);
        drive();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst at fetch ready", 32'(rdy), 32'd0);
        drive();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst prescaler", 32'(tx_p), 32'd16);
        chk("post rst left", 32'(tx_l), 32'd0);
        chk("post rst cnt", 32'(ucnt), 32'd0);
        chk("post rst gid", 32'(gid), 32'd0);
        chk("post rst tx_rst_n", 32'(tx_rst_n), 32'd0);
        chk("post rst strobe", 32'(strobe), 32'd0);

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            drive();
            valid     = NS'($urandom);
            mask      = ($urandom_range(0, 3) == 0) ? NS'($urandom) : 4'hF;
            src_l     = {$urandom, $urandom};
            src_r     = {$urandom, $urandom};
            prescaler = DW'($urandom_range(0, 40));
            if ($urandom_range(0, 29) == 0) mute = ~mute;
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            clr   = ($urandom_range(0, 49) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
        end
        drive();
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
